// File: rtl/ws2812_frame_streamer.sv
// WS2812 frame streamer: holds a frame of 24-bit GRB pixels in a small RAM
// and offers them MSB-first, one bit per valid/ready handshake, to the
// bit-timing encoder. After the last bit it keeps the link quiet for the
// latch gap, then pulses done.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; read address parked on pixel 0
// S_LOAD  | RAM read data for the current pixel moves into r_shift
// S_SHIFT | offering r_shift[23]; shifts on each accepted bit
// S_LATCH | link quiet; latch counter runs once the encoder reports idle
module ws2812_frame_streamer #(
   parameter int  NUM_PIXELS   = 16,
   parameter int  LATCH_CYCLES = 2600,
   localparam int AW           = $clog2(NUM_PIXELS),
   localparam int LW           = $clog2(NUM_PIXELS + 1),
   localparam int CW           = $clog2(LATCH_CYCLES + 1)
) (
   input  logic          CLOCK_50,
   input  logic          RESET_N,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data,
   input  logic          start,
   input  logic [LW-1:0] frame_len,
   output logic          bit_valid,
   output logic          bit_value,
   input  logic          bit_ready,
   input  logic          link_idle,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [23:0]   r_ram [NUM_PIXELS];
   logic [23:0]   r_rd_data;
   logic [23:0]   r_shift;
   logic [AW-1:0] r_pix_idx;
   logic [AW-1:0] w_rd_addr;
   logic [LW-1:0] r_len;
   logic [LW-1:0] w_len_clip;
   logic [4:0]    r_bit_cnt;
   logic [CW-1:0] r_lat_cnt;
   logic          r_counting;
   logic          w_hs;
   logic          w_last_pix;
   logic          w_done;
   logic          w_start_ok;

   assign w_len_clip = (frame_len > LW'(NUM_PIXELS)) ? LW'(NUM_PIXELS) : frame_len;
   assign w_hs       = (r_state == S_SHIFT) && bit_ready;
   assign w_last_pix = (LW'(r_pix_idx) == (r_len - LW'(1)));
   assign w_done     = (r_state == S_LATCH) && (r_lat_cnt == '0);
   assign w_start_ok = start && ((r_state == S_IDLE) || w_done);

   // State register; reset aborts any frame in flight.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next state, link outputs and RAM read address.
   always_comb begin
      w_next    = r_state;
      bit_valid = 1'b0;
      bit_value = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      w_rd_addr = '0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = (w_len_clip == '0) ? S_LATCH : S_LOAD;
         end
         S_LOAD: begin
            busy   = 1'b1;
            w_next = S_SHIFT;
         end
         S_SHIFT: begin
            busy      = 1'b1;
            bit_valid = 1'b1;
            bit_value = r_shift[23];
            // Prefetch the next pixel so it is ready when LOAD runs.
            w_rd_addr = r_pix_idx + AW'(1);
            if (w_hs && (r_bit_cnt == 5'd0)) w_next = w_last_pix ? S_LATCH : S_LOAD;
         end
         S_LATCH: begin
            if (w_done) begin
               done = 1'b1;
               if (start) w_next = (w_len_clip == '0) ? S_LATCH : S_LOAD;
               else       w_next = S_IDLE;
            end else begin
               busy = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Pixel RAM: one write port, registered read returning pre-write data.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en) r_ram[wr_addr] <= wr_data;
      r_rd_data <= r_ram[w_rd_addr];
   end

   // Shift register, bit/pixel counters and latch-gap timer.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_pix_idx  <= '0;
         r_len      <= '0;
         r_lat_cnt  <= '0;
         r_counting <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_shift   <= r_rd_data;
               r_bit_cnt <= 5'd23;
            end
            S_SHIFT: begin
               if (w_hs) begin
                  r_shift <= {r_shift[22:0], 1'b0};
                  if (r_bit_cnt != 5'd0) begin
                     r_bit_cnt <= r_bit_cnt - 5'd1;
                  end else if (w_last_pix) begin
                     r_lat_cnt  <= CW'(LATCH_CYCLES);
                     r_counting <= 1'b0;
                  end else begin
                     r_pix_idx <= r_pix_idx + AW'(1);
                  end
               end
            end
            S_LATCH: begin
               // Once the encoder has gone idle the gap runs to completion.
               if (link_idle) r_counting <= 1'b1;
               if (r_counting && (r_lat_cnt != '0)) r_lat_cnt <= r_lat_cnt - CW'(1);
            end
            default: ;
         endcase
         if (w_start_ok) begin
            r_len      <= w_len_clip;
            r_pix_idx  <= '0;
            r_lat_cnt  <= CW'(LATCH_CYCLES);
            r_counting <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// Bench for ws2812_frame_streamer: table of frame scenarios checked against
// a pixel-array model of the expected bit stream and latch-gap timing, plus
// hand-written reset and back-to-back sequences.
module tb_ws2812_frame_streamer;
   localparam int NP = 16;
   localparam int LC = 2600;
   localparam int AW = 4;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [23:0]   wr_data = '0;
   logic          start = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic          bit_valid;
   logic          bit_value;
   logic          bit_ready = 1'b0;
   logic          link_idle = 1'b0;
   logic          busy;
   logic          done;

   int checks = 0;
   int failures = 0;
   logic [23:0] model_ram [NP];

   typedef struct {
      int          len;
      int          ready_mode;
      int          idle_delay;
      int          exp_bits;
      int          wr_bit;
      int          wr_addr;
      logic [23:0] wr_val;
      int          busy_start_bit;
      int          chain_len;
      int          chained;
   } vec_t;

   vec_t vecs [9];

   always #10 clk = ~clk;

   ws2812_frame_streamer #(.NUM_PIXELS(NP), .LATCH_CYCLES(LC)) dut (
      .CLOCK_50  (clk),
      .RESET_N   (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .frame_len (frame_len),
      .bit_valid (bit_valid),
      .bit_value (bit_value),
      .bit_ready (bit_ready),
      .link_idle (link_idle),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pix(input int a, input logic [23:0] d);
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      model_ram[a] = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      logic exp_q[$];
      int   eff_len, got, bad, stab, rise, done_at, last_bit;
      bit   prev_pend, prev_val, wr_done, bs_done;
      eff_len = (v.len > NP) ? NP : v.len;
      for (int p = 0; p < eff_len; p++)
         for (int b = 23; b >= 0; b--) exp_q.push_back(model_ram[p][b]);
      got = 0; bad = -1; stab = 0; rise = -1; done_at = -1; last_bit = -1;
      prev_pend = 0; prev_val = 0; wr_done = 0; bs_done = 0;
      link_idle = 1'b0;
      if (v.chained == 0) begin
         frame_len = LW'(v.len);
         start = 1'b1;
      end
      tick();
      start = 1'b0;
      check($sformatf("v%0d_busy_after_start", idx), busy, 1);
      for (int it = 0; it < 20000 && done_at < 0; it++) begin
         if (it > 0) tick();
         bit_ready = (v.ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         wr_en = 1'b0;
         start = 1'b0;
         if (v.wr_bit >= 0 && got == v.wr_bit && !wr_done) begin
            wr_done = 1;
            wr_en = 1'b1;
            wr_addr = AW'(v.wr_addr);
            wr_data = v.wr_val;
            model_ram[v.wr_addr] = v.wr_val;
            // Only pixels the frame has not yet reached pick up the new value.
            if (v.wr_addr > got / 24 && v.wr_addr < eff_len)
               for (int b = 0; b < 24; b++) exp_q[v.wr_addr * 24 + b] = v.wr_val[23 - b];
         end
         if (v.busy_start_bit >= 0 && got == v.busy_start_bit && !bs_done) begin
            bs_done = 1;
            start = 1'b1;
            frame_len = LW'(1);
         end
         if (rise < 0 && got >= v.exp_bits && it >= last_bit + 1 + v.idle_delay) begin
            link_idle = 1'b1;
            rise = it;
         end
         if (prev_pend && !(bit_valid && bit_value == prev_val)) stab++;
         if (done) begin
            done_at = it;
            check($sformatf("v%0d_busy_in_done", idx), busy, 0);
            if (v.chain_len > 0) begin
               start = 1'b1;
               frame_len = LW'(v.chain_len);
            end
         end else if (bit_valid && bit_ready) begin
            if (bad < 0 && (got >= exp_q.size() || exp_q[got] !== bit_value)) bad = got;
            got++;
            last_bit = it;
         end
         prev_pend = bit_valid && !bit_ready;
         prev_val = bit_value;
      end
      wr_en = 1'b0;
      check($sformatf("v%0d_bit_count", idx), got, v.exp_bits);
      check($sformatf("v%0d_first_bad_bit", idx), bad, -1);
      check($sformatf("v%0d_value_moved_while_stalled", idx), stab, 0);
      check($sformatf("v%0d_done_seen", idx), done_at >= 0, 1);
      if (done_at >= 0) begin
         check($sformatf("v%0d_done_after_idle", idx), done_at - rise, LC + 1);
         check($sformatf("v%0d_done_after_last_bit", idx), done_at - last_bit,
               v.idle_delay + LC + 2);
      end
      if (v.chain_len == 0) begin
         tick();
         check($sformatf("v%0d_done_one_cycle", idx), done, 0);
         check($sformatf("v%0d_idle_after_done", idx), busy, 0);
      end
      link_idle = 1'b0;
   endtask

   initial begin
      // len ready idle exp wr_bit wr_addr wr_val busy_start chain chained
      vecs[0] = '{1,  0, 0,    24,  -1, 0, 24'h0,      -1, 0, 0};
      vecs[1] = '{16, 1, 0,    384, -1, 0, 24'h0,      -1, 0, 0};
      vecs[2] = '{0,  0, 0,    0,   -1, 0, 24'h0,      -1, 0, 0};
      vecs[3] = '{20, 1, 0,    384, -1, 0, 24'h0,      -1, 0, 0};
      vecs[4] = '{16, 1, 0,    384, 58, 5, 24'h123456, 30, 0, 0};
      vecs[5] = '{8,  0, 0,    192, 58, 2, 24'hFEDCBA, -1, 0, 0};
      vecs[6] = '{2,  0, 1000, 48,  -1, 0, 24'h0,      -1, 0, 0};
      vecs[7] = '{3,  1, 0,    72,  -1, 0, 24'h0,      -1, 2, 0};
      vecs[8] = '{2,  1, 3,    48,  -1, 0, 24'h0,      -1, 0, 1};

      #5;
      check("reset_bit_valid", bit_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      tick(); tick();
      #4 rst_n = 1'b1;
      tick();

      write_pix(0, 24'hA50F81);
      for (int p = 1; p < NP; p++) write_pix(p, 24'($urandom()));

      for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

      // Reset in the middle of shifting drops everything at once.
      frame_len = LW'(16);
      bit_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      check("pre_reset_bit_valid", bit_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_bit_valid", bit_valid, 0);
      check("async_reset_busy", busy, 0);
      check("async_reset_done", done, 0);
      tick();
      #4 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("post_reset_idle_%0d", i), {bit_valid, busy, done}, 0);
      end

      // RAM survives reset: the single-pixel frame still sends A50F81.
      run_frame(vecs[0], 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
